// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register countdown scoreboard that stalls decode on pending writes
// Ports: clk/rst_n (async active-low); id_valid, rs/rt source fields, rd/rd_write/rd_lat
// destination fields, flush in; stall, issue, busy_vec (counter!=0), stall_count out.
module hazard_scoreboard #(
    parameter int NUM_REGS    = 8,
    parameter int REG_W       = 3,
    parameter int LAT_W       = 2,
    parameter int MAX_LAT     = 3,
    parameter int FWD_SLACK   = 0,
    parameter int ZERO_REG_HW = 0,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                id_valid,
    input  logic [REG_W-1:0]    rs_addr,
    input  logic                rs_used,
    input  logic [REG_W-1:0]    rt_addr,
    input  logic                rt_used,
    input  logic [REG_W-1:0]    rd_addr,
    input  logic                rd_write,
    input  logic [LAT_W-1:0]    rd_lat,
    input  logic                flush,
    output logic                stall,
    output logic                issue,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic [CNT_W-1:0]    stall_count
);
    logic [LAT_W-1:0] cnt [NUM_REGS];
    logic             haz_s, haz_t, track;
    logic [LAT_W-1:0] lat_c;
    // Hazards use the counters as they stand before this edge's update.
    always_comb begin
        haz_s = rs_used && (int'(cnt[rs_addr]) > FWD_SLACK);
        haz_t = rt_used && (int'(cnt[rt_addr]) > FWD_SLACK);
        stall = id_valid && !flush && (haz_s || haz_t);
        issue = id_valid && !flush && !stall;
        lat_c = (int'(rd_lat) > MAX_LAT) ? LAT_W'(MAX_LAT) : rd_lat;
        track = issue && rd_write && !(ZERO_REG_HW != 0 && rd_addr == '0);
        for (int r = 0; r < NUM_REGS; r++) busy_vec[r] = (cnt[r] != '0);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
            stall_count <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++)
                cnt[r] <= flush ? '0 :
                          (track && rd_addr == REG_W'(r)) ? lat_c :
                          (cnt[r] != '0) ? cnt[r] - 1'b1 : cnt[r];
            if (stall && !(&stall_count)) stall_count <= stall_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: checks two scoreboard configurations against a ready-time model
module tb_hazard_scoreboard;
    logic clk = 0, rst_n = 0;
    logic id_valid = 0, rs_used = 0, rt_used = 0, rd_write = 0, flush = 0;
    logic [2:0] rs_addr = 0, rt_addr = 0, rd_addr = 0;
    logic [1:0] rd_lat = 0;
    logic stall0, issue0, stall1, issue1;
    logic [7:0] busy0, busy1;
    logic [15:0] sc0;
    logic [1:0] sc1;
    int tests = 0, fails = 0;
    int cyc = 0;
    int ready [2][8];
    int scount [2];
    int fwd [2] = '{0, 1};
    int zhw [2] = '{0, 1};
    int maxl [2] = '{3, 2};
    int cmax [2] = '{65535, 3};

    always #5 clk = ~clk;

    hazard_scoreboard dut0 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .rs_addr(rs_addr), .rs_used(rs_used),
        .rt_addr(rt_addr), .rt_used(rt_used), .rd_addr(rd_addr), .rd_write(rd_write),
        .rd_lat(rd_lat), .flush(flush), .stall(stall0), .issue(issue0),
        .busy_vec(busy0), .stall_count(sc0));

    hazard_scoreboard #(.FWD_SLACK(1), .ZERO_REG_HW(1), .MAX_LAT(2), .CNT_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .rs_addr(rs_addr), .rs_used(rs_used),
        .rt_addr(rt_addr), .rt_used(rt_used), .rd_addr(rd_addr), .rd_write(rd_write),
        .rd_lat(rd_lat), .flush(flush), .stall(stall1), .issue(issue1),
        .busy_vec(busy1), .stall_count(sc1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model: a register's value is available from cycle ready[k][r]; pending = cycles left.
    function automatic int pend(input int k, input int r);
        return ready[k][r] > cyc ? ready[k][r] - cyc : 0;
    endfunction

    function automatic bit m_stall(input int k);
        bit hs = rs_used && pend(k, int'(rs_addr)) > fwd[k];
        bit ht = rt_used && pend(k, int'(rt_addr)) > fwd[k];
        return id_valid && !flush && (hs || ht);
    endfunction

    function automatic logic [7:0] m_busy(input int k);
        logic [7:0] b;
        for (int r = 0; r < 8; r++) b[r] = pend(k, r) > 0;
        return b;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            scount[k] = 0;
            for (int r = 0; r < 8; r++) ready[k][r] = 0;
        end
    endtask

    task automatic compare();
        check("stall0", 32'(stall0), 32'(m_stall(0)));
        check("issue0", 32'(issue0), 32'(id_valid && !flush && !m_stall(0)));
        check("busy0", 32'(busy0), 32'(m_busy(0)));
        check("sc0", 32'(sc0), 32'(scount[0]));
        check("stall1", 32'(stall1), 32'(m_stall(1)));
        check("issue1", 32'(issue1), 32'(id_valid && !flush && !m_stall(1)));
        check("busy1", 32'(busy1), 32'(m_busy(1)));
        check("sc1", 32'(sc1), 32'(scount[1]));
    endtask

    task automatic model_step();
        bit st [2];
        for (int k = 0; k < 2; k++) st[k] = m_stall(k);
        for (int k = 0; k < 2; k++) begin
            if (st[k] && scount[k] < cmax[k]) scount[k]++;
            if (flush) begin
                for (int r = 0; r < 8; r++) ready[k][r] = 0;
            end else if (id_valid && !st[k] && rd_write && !(zhw[k] == 1 && rd_addr == 0)) begin
                ready[k][rd_addr] = cyc + 1 + (int'(rd_lat) < maxl[k] ? int'(rd_lat) : maxl[k]);
            end
        end
    endtask

    // Inputs are driven just after a falling edge; outputs compared 1 time unit later.
    task automatic cycle(input bit v, input int rs, input bit rsu, input int rt, input bit rtu,
                         input int rd, input bit rdw, input int lat, input bit fl);
        id_valid = v; rs_addr = 3'(rs); rs_used = rsu; rt_addr = 3'(rt); rt_used = rtu;
        rd_addr = 3'(rd); rd_write = rdw; rd_lat = 2'(lat); flush = fl;
        #1;
        compare();
        model_step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        id_valid = 1; rs_used = 1;
        #7;
        check("rst_stall0", 32'(stall0), 0);
        check("rst_issue0", 32'(issue0), 1);
        check("rst_busy0", 32'(busy0), 0);
        check("rst_sc0", 32'(sc0), 0);
        @(negedge clk);
        rst_n = 1;
        // RAW on r3 with latency 3, then keep reading r3
        cycle(1, 0, 0, 0, 0, 3, 1, 3, 0);
        for (int i = 0; i < 5; i++) cycle(1, 3, 1, 3, 0, 1, 0, 0, 0);
        check("raw_sc0", 32'(sc0), 3);
        // rt unused never hazards
        cycle(1, 0, 0, 0, 0, 3, 1, 3, 0);
        cycle(1, 0, 0, 3, 0, 0, 0, 0, 0);
        check("rt_unused_stall0", 32'(stall0), 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Flush with r2 and r5 pending, a reader of r5 waiting
        cycle(1, 0, 0, 0, 0, 2, 1, 2, 0);
        cycle(1, 0, 0, 0, 0, 5, 1, 3, 0);
        cycle(1, 5, 1, 0, 0, 0, 0, 0, 1);
        check("post_flush_busy0", 32'(busy0), 0);
        cycle(1, 5, 1, 0, 0, 0, 0, 0, 0);
        // Zero register: untracked in dut1, tracked in dut0
        cycle(1, 0, 0, 0, 0, 0, 1, 3, 0);
        check("zreg_busy1", 32'(busy1[0]), 0);
        cycle(1, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Clamp: dut1 holds r4 busy for exactly MAX_LAT=2 cycles
        cycle(1, 0, 0, 0, 0, 4, 1, 3, 0);
        check("clamp_b1a", 32'(busy1[4]), 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("clamp_b1b", 32'(busy1[4]), 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("clamp_b1c", 32'(busy1[4]), 0);
        // Reload: rd=6 lat1 then lat3 overwrites
        cycle(1, 0, 0, 0, 0, 6, 1, 1, 0);
        cycle(1, 0, 0, 0, 0, 6, 1, 3, 0);
        check("reload_cnt0", 32'(dut0.cnt[6]), 3);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Force stalls until dut1's 2-bit counter saturates
        cycle(1, 0, 0, 0, 0, 1, 1, 3, 0);
        for (int j = 0; j < 3; j++) begin
            cycle(1, 1, 1, 0, 0, 1, 1, 3, 0);
            cycle(1, 1, 1, 0, 0, 1, 1, 3, 0);
            cycle(1, 1, 1, 0, 0, 1, 1, 3, 0);
        end
        check("sat_sc1", 32'(sc1), 3);
        // Asynchronous reset while stalling
        cycle(1, 0, 0, 0, 0, 7, 1, 3, 0);
        id_valid = 1; rs_addr = 7; rs_used = 1; rd_write = 0;
        #2;
        rst_n = 0;
        #1;
        check("amid_stall0", 32'(stall0), 0);
        check("amid_busy0", 32'(busy0), 0);
        check("amid_sc0", 32'(sc0), 0);
        check("amid_sc1", 32'(sc1), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        // Randomised traffic
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(3, 0) != 0, $urandom_range(7, 0), $urandom_range(1, 0) == 1,
                  $urandom_range(7, 0), $urandom_range(1, 0) == 1, $urandom_range(7, 0),
                  $urandom_range(3, 0) != 0, $urandom_range(3, 0), $urandom_range(15, 0) == 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
